chunked_comparator: RTL and testbench

Parametrised, multi-cycle successor to the ALU's combinational 32-bit comparator. It compares A and B one CHUNK-bit slice per cycle, starting at the most significant slice. It stops early at the first differing slice. Valid/ready handshakes on input and output let branch/SLT logic at wide WIDTH trade latency for a short critical path. Opcode encoding is identical to the existing ALU compare opcodes.

---
 rtl/chunked_comparator.sv | 164 ++++++++++++++++
 tb/tb_chunked_comparator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_comparator.sv
// chunked_comparator: multi-cycle magnitude/equality comparator.
//
// Compares A and B one CHUNK-bit slice per cycle, starting at the most
// significant slice, and stops at the first slice that differs. A single
// transaction is in flight at a time, with valid/ready handshakes on both
// sides. Outputs come from registers only.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     request present
//   in_ready     block can accept a request (IDLE only)
//   A, B         operands
//   opcode       0100 SLT, 0101 SGT, 0110 SLTU, 0111 SGTU, 1000 EQ, 1001 NE
//   out_valid    result available (DONE)
//   out_ready    consumer accepts result
//   Result       boolean result, zero-extended to WIDTH
//   ZeroFlag     high when Result == 0
//   out_illegal  the accepted opcode was not a compare opcode
module chunked_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroFlag,
    output logic             out_illegal
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0]  TopIdx  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

    localparam logic [3:0] OpSlt  = 4'b0100;
    localparam logic [3:0] OpSgt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;
    localparam logic [3:0] OpSgtu = 4'b0111;
    localparam logic [3:0] OpEq   = 4'b1000;
    localparam logic [3:0] OpNe   = 4'b1001;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             res_q, res_d;
    logic             illegal_q, illegal_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             op_legal;
    logic             op_signed;

    // Maps the slice outcome onto the boolean the opcode asks for.
    function automatic logic eval_res(input logic [3:0] op, input logic lt,
                                      input logic gt, input logic eq);
        logic r;
        r = 1'b0;
        case (op)
            OpSlt, OpSltu: r = lt;
            OpSgt, OpSgtu: r = gt;
            OpEq:          r = eq;
            OpNe:          r = ~eq;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    assign op_legal  = (opcode >= OpSlt) && (opcode <= OpNe);
    assign op_signed = (opcode == OpSlt) || (opcode == OpSgt);

    assign a_sl = a_q[idx_q*CHUNK +: CHUNK];
    assign b_sl = b_q[idx_q*CHUNK +: CHUNK];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        res_d     = res_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Flipping the sign bit of both operands turns two's-complement
                    // ordering into unsigned ordering, so every slice compares unsigned.
                    a_d       = op_signed ? (A ^ MsbMask) : A;
                    b_d       = op_signed ? (B ^ MsbMask) : B;
                    op_d      = opcode;
                    idx_d     = TopIdx;
                    illegal_d = ~op_legal;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (illegal_q) begin
                    // Illegal ops spend one cycle here so they share the
                    // single-slice latency.
                    res_d   = 1'b0;
                    state_d = StDone;
                end else if (a_sl != b_sl) begin
                    res_d   = eval_res(op_q, a_sl < b_sl, a_sl > b_sl, 1'b0);
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    res_d   = eval_res(op_q, 1'b0, 1'b0, 1'b1);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= TopIdx;
            res_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign Result      = WIDTH'(res_q);
    assign ZeroFlag    = ~res_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_chunked_comparator.sv
// Self-checking bench for chunked_comparator (WIDTH=32, CHUNK=8).
// Expected results come from a full-width reference model and are queued
// when a request is driven, then popped when the DUT presents its result.
module tb_chunked_comparator;

    localparam int WIDTH   = 32;
    localparam int CHUNK   = 8;
    localparam int NCHUNK  = WIDTH / CHUNK;
    localparam int TIMEOUT = 20;

    typedef struct packed {
        logic res;
        logic ill;
        int   lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [3:0]       opcode = 4'b0000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] Result;
    logic             ZeroFlag;
    logic             out_illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    chunked_comparator #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .ZeroFlag   (ZeroFlag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: full-width compare; latency = slices down to the first difference.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [3:0] op);
        exp_t e;
        logic found;
        e.res = 1'b0;
        e.ill = 1'b0;
        e.lat = NCHUNK;
        found = 1'b0;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (!found && (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK])) begin
                e.lat = NCHUNK - i;
                found = 1'b1;
            end
        end
        case (op)
            4'b0100: e.res = ($signed(a) < $signed(b));
            4'b0101: e.res = ($signed(a) > $signed(b));
            4'b0110: e.res = (a < b);
            4'b0111: e.res = (a > b);
            4'b1000: e.res = (a == b);
            4'b1001: e.res = (a != b);
            default: begin
                e.ill = 1'b1;
                e.lat = 1;
            end
        endcase
        return e;
    endfunction

    // Queues the expectation, performs one accept, then counts edges to out_valid.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] op, output int lat);
        exp_q.push_back(model(a, b, op));
        @(negedge clk);
        A        = a;
        B        = b;
        opcode   = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operand changes after accept must not matter.
        A        = $urandom;
        B        = $urandom;
        lat      = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (Result !== '0 || ZeroFlag !== 1'b1 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got Result=%h Zero=%b ill=%b want 0 1 0",
                     Result, ZeroFlag, out_illegal);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_compare_ops();
        logic [WIDTH-1:0] ta[9];
        logic [WIDTH-1:0] tb[9];
        logic [3:0]       top[9];
        int               lat;
        exp_t             e;
        ta  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h00010000,
                32'h00000102, 32'h80000000, 32'h12345678, 32'h00000005};
        tb  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h12345678, 32'h00000000,
                32'h00000101, 32'h7FFFFFFF, 32'h12345678, 32'h80000005};
        top = '{4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
                4'b0111, 4'b0101, 4'b1001, 4'b0100};
        for (int i = 0; i < 9; i++) begin
            send(ta[i], tb[i], top[i], lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL op%0d_latency got %0d want %0d", i, lat, e.lat);
            end
            checks++;
            if (Result !== WIDTH'(e.res) || ZeroFlag !== ~e.res || out_illegal !== e.ill) begin
                errors++;
                $display("FAIL op%0d_result got Result=%h Zero=%b ill=%b want %h %b %b",
                         i, Result, ZeroFlag, out_illegal, WIDTH'(e.res), ~e.res, e.ill);
            end
            release_out();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_release got in_ready=%b out_valid=%b want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        send(32'h0000_0003, 32'h0000_0009, 4'b0011, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || Result !== '0 || out_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal got lat=%0d Result=%h ill=%b want %0d 0 1",
                     lat, Result, out_illegal, e.lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== '0 ||
                out_illegal !== 1'b1 || ZeroFlag !== 1'b1) begin
                errors++;
                $display("FAIL hold%0d got v=%b rdy=%b Result=%h ill=%b zf=%b want 1 0 0 1 1",
                         c, out_valid, in_ready, Result, out_illegal, ZeroFlag);
            end
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        // A legal op afterwards clears out_illegal.
        send(32'hCAFE0000, 32'hCAFE0000, 4'b1000, lat);
        e = exp_q.pop_front();
        checks++;
        if (out_illegal !== e.ill || Result !== WIDTH'(e.res) || lat !== e.lat) begin
            errors++;
            $display("FAIL ill_clear got ill=%b Result=%h lat=%0d want %b %h %0d",
                     out_illegal, Result, lat, e.ill, WIDTH'(e.res), e.lat);
        end
        release_out();
    endtask

    task automatic test_reset_mid_scan();
        int   lat;
        int   seen;
        exp_t e;
        @(negedge clk);
        A        = 32'hA5A5A5A5;
        B        = 32'hA5A5A5A5;
        opcode   = 4'b1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL aborted_output got %0d valid cycles want 0", seen);
        end
        send(32'd3, 32'd5, 4'b0110, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || Result !== WIDTH'(e.res)) begin
            errors++;
            $display("FAIL post_reset_sltu got lat=%0d Result=%h want %0d %h",
                     lat, Result, e.lat, WIDTH'(e.res));
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        int               c;
        int               lat;
        exp_t             e;
        for (int i = 0; i < 30; i++) begin
            a  = $urandom;
            b  = a;
            op = 4'($urandom_range(3, 10));
            c  = $urandom_range(0, NCHUNK);
            if (c < NCHUNK) b[c*CHUNK +: CHUNK] = b[c*CHUNK +: CHUNK] ^ 8'($urandom_range(1, 255));
            if (i % 7 == 0) b = $urandom;
            send(a, b, op, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat || Result !== WIDTH'(e.res) || ZeroFlag !== ~e.res ||
                out_illegal !== e.ill) begin
                errors++;
                $display("FAIL rnd%0d a=%h b=%h op=%b got lat=%0d Result=%h zf=%b ill=%b want %0d %h %b %b",
                         i, a, b, op, lat, Result, ZeroFlag, out_illegal,
                         e.lat, WIDTH'(e.res), ~e.res, e.ill);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_compare_ops();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
